// File: rtl/prep9_bus_master.sv
// Burst bus initiator for the prep9 decoder: issues AH/AL/AS strobes over an
// address range and checks each registered decoder response against the map.
module prep9_bus_master #(
  parameter int GAP_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [15:0]      BASE,
  input  logic [CNT_W-1:0] COUNT,
  input  logic [GAP_W-1:0] GAP,
  input  logic             ERR_CLR,
  output logic [7:0]       AH,
  output logic [7:0]       AL,
  output logic             AS,
  input  logic [7:0]       SEL,
  input  logic             BE_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [15:0]      ERR_ADDR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_DRAIN,
    ST_FIN
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      addr, addr_nxt;
  logic [CNT_W-1:0] remain, remain_nxt;
  logic [GAP_W-1:0] gaplen, gaplen_nxt;
  logic [GAP_W-1:0] gapcnt, gapcnt_nxt;
  logic             as_nxt;
  logic [15:0]      bus_nxt;

  logic             pipe_valid;
  logic [15:0]      pipe_addr;
  logic [7:0]       exp_sel;
  logic             exp_be;
  logic             mismatch;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      addr   <= '0;
      remain <= '0;
      gaplen <= '0;
      gapcnt <= '0;
      AS     <= 1'b0;
      AH     <= '0;
      AL     <= '0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      remain <= remain_nxt;
      gaplen <= gaplen_nxt;
      gapcnt <= gapcnt_nxt;
      AS     <= as_nxt;
      AH     <= bus_nxt[15:8];
      AL     <= bus_nxt[7:0];
    end
  end

  // The bus only moves when a strobe is issued, so AH/AL hold during gaps.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    remain_nxt = remain;
    gaplen_nxt = gaplen;
    gapcnt_nxt = gapcnt;
    as_nxt     = 1'b0;
    bus_nxt    = {AH, AL};
    case (state)
      ST_IDLE: begin
        if (START) begin
          if (COUNT != '0) begin
            addr_nxt   = BASE;
            remain_nxt = COUNT;
            gaplen_nxt = GAP;
            state_nxt  = ST_ISSUE;
            as_nxt     = 1'b1;
            bus_nxt    = BASE;
          end else begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_ISSUE: begin
        remain_nxt = remain - CNT_W'(1);
        if (remain == CNT_W'(1)) begin
          state_nxt = ST_DRAIN;
        end else begin
          addr_nxt = addr + 16'd1;
          if (gaplen == '0) begin
            as_nxt  = 1'b1;
            bus_nxt = addr + 16'd1;
          end else begin
            state_nxt  = ST_GAP;
            gapcnt_nxt = gaplen;
          end
        end
      end
      ST_GAP: begin
        if (gapcnt == GAP_W'(1)) begin
          state_nxt = ST_ISSUE;
          as_nxt    = 1'b1;
          bus_nxt   = addr;
        end else begin
          gapcnt_nxt = gapcnt - GAP_W'(1);
        end
      end
      ST_DRAIN: state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign BUSY = (state == ST_ISSUE) || (state == ST_GAP) || (state == ST_DRAIN);
  assign DONE = (state == ST_FIN);

  // One-stage delay matching the decoder's registered response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pipe_valid <= 1'b0;
      pipe_addr  <= '0;
    end else begin
      pipe_valid <= AS;
      pipe_addr  <= {AH, AL};
    end
  end

  always_comb begin
    exp_sel = 8'h00;
    exp_be  = 1'b0;
    if (pipe_addr <= 16'hE2AA)      exp_be  = 1'b1;
    else if (pipe_addr == 16'hE2AB) exp_sel = 8'h80;
    else if (pipe_addr <= 16'hE2AF) exp_sel = 8'h40;
    else if (pipe_addr <= 16'hE2BF) exp_sel = 8'h20;
    else if (pipe_addr <= 16'hE2FF) exp_sel = 8'h10;
    else if (pipe_addr <= 16'hE3FF) exp_sel = 8'h08;
    else if (pipe_addr <= 16'hE7FF) exp_sel = 8'h04;
    else if (pipe_addr <= 16'hEFFF) exp_sel = 8'h02;
    else                            exp_sel = 8'h01;
  end

  // With no strobe in flight the decoder holds BE, so only SEL is checked.
  assign mismatch = pipe_valid ? ((SEL != exp_sel) || (BE_IN != exp_be))
                               : (SEL != 8'h00);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR      <= 1'b0;
      ERR_ADDR <= '0;
    end else if (mismatch) begin
      ERR <= 1'b1;
      if (!ERR || ERR_CLR) ERR_ADDR <= pipe_addr;
    end else if (ERR_CLR) begin
      ERR      <= 1'b0;
      ERR_ADDR <= '0;
    end
  end

endmodule

// File: tb/tb_prep9_bus_master.sv
// Scoreboard bench for prep9_bus_master with a behavioural decoder attached
// and hooks to corrupt selected responses.
module tb_prep9_bus_master;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [15:0] BASE;
  logic [15:0] COUNT;
  logic [3:0]  GAP;
  logic        ERR_CLR;
  logic [7:0]  AH, AL;
  logic        AS;
  logic [7:0]  SEL;
  logic        BE_IN;
  logic        BUSY, DONE, ERR;
  logic [15:0] ERR_ADDR;

  logic [7:0]  decSel;
  logic        decBe;
  logic        decAs;
  logic [15:0] decAddr;
  logic        injEn;
  logic        forceIdle;

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } strobe_t;

  strobe_t expQ[$];
  int      doneQ[$];
  int      cyc;
  int      errors;
  int      checks;

  prep9_bus_master #(.GAP_W(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .COUNT(COUNT),
    .GAP(GAP), .ERR_CLR(ERR_CLR), .AH(AH), .AL(AL), .AS(AS), .SEL(SEL),
    .BE_IN(BE_IN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_ADDR(ERR_ADDR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Hand-written decoder address map, independent of the design.
  function automatic logic [8:0] decode(input logic [15:0] a);
    case (a) inside
      [16'h0000:16'hE2AA]: decode = {1'b1, 8'h00};
      16'hE2AB:            decode = {1'b0, 8'h80};
      [16'hE2AC:16'hE2AF]: decode = {1'b0, 8'h40};
      [16'hE2B0:16'hE2BF]: decode = {1'b0, 8'h20};
      [16'hE2C0:16'hE2FF]: decode = {1'b0, 8'h10};
      [16'hE300:16'hE3FF]: decode = {1'b0, 8'h08};
      [16'hE400:16'hE7FF]: decode = {1'b0, 8'h04};
      [16'hE800:16'hEFFF]: decode = {1'b0, 8'h02};
      default:             decode = {1'b0, 8'h01};
    endcase
  endfunction

  // Registered decoder: BE holds while no strobe is presented.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      decSel  <= 8'h00;
      decBe   <= 1'b0;
      decAs   <= 1'b0;
      decAddr <= 16'h0000;
    end else begin
      decAs   <= AS;
      decAddr <= {AH, AL};
      if (AS) {decBe, decSel} <= decode({AH, AL});
      else    decSel <= 8'h00;
    end
  end

  assign SEL = (injEn && decAs && (decAddr == 16'hE2B0 || decAddr == 16'hE2B1)) ? 8'h40 :
               (forceIdle ? 8'h04 : decSel);
  assign BE_IN = decBe;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes or signals done.
  always @(negedge CLK) begin
    if (!RST && AS) begin
      if (expQ.size() == 0) begin
        failNow("unexpected_strobe");
      end else begin
        strobe_t e;
        e = expQ.pop_front();
        checkOutput("strobe_addr", {16'h0, AH, AL}, {16'h0, e.addr});
        checkOutput("strobe_cycle", cyc, e.cyc);
        checkOutput("busy_at_strobe", {31'h0, BUSY}, 32'h1);
      end
    end
    if (!RST && DONE) begin
      if (doneQ.size() == 0) begin
        failNow("unexpected_done");
      end else begin
        int d;
        d = doneQ.pop_front();
        checkOutput("done_cycle", cyc, d);
        checkOutput("busy_at_done", {31'h0, BUSY}, 32'h0);
      end
    end
  end

  task automatic pulseStart(input logic [15:0] base, input logic [15:0] count, input logic [3:0] gap);
    @(negedge CLK);
    START = 1'b1;
    BASE  = base;
    COUNT = count;
    GAP   = gap;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Queues the strobes (at most 'limit') and the DONE cycle, then starts.
  task automatic applyStimulus(input logic [15:0] base, input logic [15:0] count,
                               input logic [3:0] gap, input int limit);
    int s;
    int last;
    strobe_t e;
    @(negedge CLK);
    s = cyc;
    last = s;
    for (int i = 0; i < count && i < limit; i++) begin
      e.addr = base + 16'(i);
      e.cyc  = s + 1 + i * (gap + 1);
      expQ.push_back(e);
    end
    if (limit >= count) begin
      if (count == 0) doneQ.push_back(s + 1);
      else doneQ.push_back(s + 1 + (count - 1) * (gap + 1) + 2);
    end
    START = 1'b1;
    BASE  = base;
    COUNT = count;
    GAP   = gap;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((expQ.size() != 0 || doneQ.size() != 0) && n < budget) begin
      @(posedge CLK);
      n++;
    end
    if (n >= budget) begin
      failNow("burst_timeout");
      expQ.delete();
      doneQ.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    errors = 0; checks = 0; cyc = 0;
    RST = 1'b1; START = 1'b0; BASE = '0; COUNT = '0; GAP = '0; ERR_CLR = 1'b0;
    injEn = 1'b0; forceIdle = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("reset_as", {31'h0, AS}, 32'h0);
    checkOutput("reset_addr", {16'h0, AH, AL}, 32'h0);
    checkOutput("reset_busy", {31'h0, BUSY}, 32'h0);
    checkOutput("reset_done", {31'h0, DONE}, 32'h0);
    checkOutput("reset_err", {31'h0, ERR}, 32'h0);
    checkOutput("reset_err_addr", {16'h0, ERR_ADDR}, 32'h0);

    // Back-to-back strobes across the BE / H / G boundaries.
    applyStimulus(16'hE2A9, 16'd4, 4'd0, 100);
    waitDrain(100);
    checkOutput("t1_err", {31'h0, ERR}, 32'h0);

    // Gapped burst; a START during the gap must not add strobes.
    applyStimulus(16'hE300, 16'd3, 4'd2, 100);
    repeat (2) @(posedge CLK);
    pulseStart(16'h1234, 16'd5, 4'd0);
    waitDrain(100);
    checkOutput("t2_err", {31'h0, ERR}, 32'h0);
    checkOutput("t2_busy_after", {31'h0, BUSY}, 32'h0);

    // Address wrap FFFF -> 0000.
    applyStimulus(16'hFFFE, 16'd3, 4'd0, 100);
    waitDrain(100);
    checkOutput("t3_err", {31'h0, ERR}, 32'h0);

    // Zero-length burst: DONE only.
    applyStimulus(16'hE000, 16'd0, 4'd0, 100);
    waitDrain(100);
    checkOutput("t4_busy_after", {31'h0, BUSY}, 32'h0);
    checkOutput("t4_as", {31'h0, AS}, 32'h0);

    // Corrupted responses at E2B0 and E2B1.
    injEn = 1'b1;
    applyStimulus(16'hE2B0, 16'd2, 4'd0, 100);
    waitDrain(100);
    injEn = 1'b0;
    checkOutput("t5_err", {31'h0, ERR}, 32'h1);
    checkOutput("t5_err_addr", {16'h0, ERR_ADDR}, 32'hE2B0);
    @(negedge CLK);
    ERR_CLR = 1'b1;
    @(posedge CLK);
    #1 ERR_CLR = 1'b0;
    @(negedge CLK);
    checkOutput("t5_clr_err", {31'h0, ERR}, 32'h0);
    checkOutput("t5_clr_err_addr", {16'h0, ERR_ADDR}, 32'h0);
    ERR_CLR = 1'b1;
    forceIdle = 1'b1;
    @(posedge CLK);
    #1 ERR_CLR = 1'b0;
    forceIdle = 1'b0;
    @(negedge CLK);
    checkOutput("t5_coincident_err", {31'h0, ERR}, 32'h1);
    checkOutput("t5_coincident_err_addr", {16'h0, ERR_ADDR}, 32'hE2B1);
    ERR_CLR = 1'b1;
    @(posedge CLK);
    #1 ERR_CLR = 1'b0;
    @(negedge CLK);
    checkOutput("t5_final_clr", {31'h0, ERR}, 32'h0);

    // Reset during the third strobe, then a normal single access.
    applyStimulus(16'h1000, 16'd10, 4'd0, 2);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    checkOutput("t6_rst_as", {31'h0, AS}, 32'h0);
    checkOutput("t6_rst_busy", {31'h0, BUSY}, 32'h0);
    checkOutput("t6_rst_addr", {16'h0, AH, AL}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("t6_pending_strobes", expQ.size(), 32'h0);
    repeat (4) @(negedge CLK);
    checkOutput("t6_no_done", {31'h0, DONE}, 32'h0);
    applyStimulus(16'h0000, 16'd1, 4'd0, 100);
    waitDrain(100);
    checkOutput("t6_err", {31'h0, ERR}, 32'h0);

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
